// File: rtl/dw02_mult_pipe_hs.sv
`default_nettype none
// ============================================================================
// dw02_mult_pipe_hs : N-stage pipelined signed/unsigned multiplier, valid/ready
// Rev 1.0
// ============================================================================
module dw02_mult_pipe_hs #(
    parameter int A_width    = 16,
    parameter int B_width    = 16,
    parameter int NUM_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic [A_width-1:0]         A,
    input  logic [B_width-1:0]         B,
    input  logic                       TC,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [A_width+B_width-1:0] PRODUCT,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int PW = A_width + B_width;

    logic                  adv;
    logic                  accept;
    logic [NUM_STAGES-1:0] vld;
    logic [PW-1:0]         a_ext;
    logic [PW-1:0]         b_ext;

    // Extending to full product width makes the truncated product exact in both modes.
    assign a_ext = TC ? {{B_width{A[A_width-1]}}, A} : {{B_width{1'b0}}, A};
    assign b_ext = TC ? {{A_width{B[B_width-1]}}, B} : {{A_width{1'b0}}, B};

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld[NUM_STAGES-1];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (adv) begin
            vld[0] <= accept;
            for (int i = 1; i < NUM_STAGES; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    generate
        if (NUM_STAGES == 1) begin : g_single
            logic [PW-1:0] prod_q;

            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    prod_q <= '0;
                end else if (adv) begin
                    prod_q <= a_ext * b_ext;
                end
            end

            assign PRODUCT = prod_q;
        end else begin : g_multi
            logic [PW-1:0] op_a;
            logic [PW-1:0] op_b;
            logic [PW-1:0] prod_q [NUM_STAGES-1];

            // Operands land in stage 1; the multiply is registered in stage 2
            // and the remaining stages just delay the result.
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    op_a <= '0;
                    op_b <= '0;
                    for (int i = 0; i < NUM_STAGES - 1; i++) begin
                        prod_q[i] <= '0;
                    end
                end else if (adv) begin
                    op_a      <= a_ext;
                    op_b      <= b_ext;
                    prod_q[0] <= op_a * op_b;
                    for (int i = 1; i < NUM_STAGES - 1; i++) begin
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end

            assign PRODUCT = prod_q[NUM_STAGES-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dw02_mult_pipe_hs.sv
`default_nettype none
// ============================================================================
// tb_dw02_mult_pipe_hs : bench for three multiplier instances (3, 1, 8 stages)
// Rev 1.0
// ============================================================================
module tb_dw02_mult_pipe_hs;

    logic             CLK = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       a = '0;
    logic [7:0]       b = '0;
    logic             tc = 1'b0;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b1;
    logic [2:0]       rdy;
    logic [2:0]       ov;
    logic [2:0][15:0] prod;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         lat [3] = '{3, 1, 8};
    logic [15:0] sbq [3][$];
    logic [15:0] sb_exp;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    dw02_mult_pipe_hs #(.A_width(8), .B_width(8), .NUM_STAGES(3)) u_dut3 (
        .CLK(CLK), .rst_n(rst_n), .A(a), .B(b), .TC(tc), .in_valid(in_valid),
        .in_ready(rdy[0]), .flush(flush), .PRODUCT(prod[0]), .out_valid(ov[0]),
        .out_ready(out_ready));

    dw02_mult_pipe_hs #(.A_width(8), .B_width(8), .NUM_STAGES(1)) u_dut1 (
        .CLK(CLK), .rst_n(rst_n), .A(a), .B(b), .TC(tc), .in_valid(in_valid),
        .in_ready(rdy[1]), .flush(flush), .PRODUCT(prod[1]), .out_valid(ov[1]),
        .out_ready(out_ready));

    dw02_mult_pipe_hs #(.A_width(8), .B_width(8), .NUM_STAGES(8)) u_dut8 (
        .CLK(CLK), .rst_n(rst_n), .A(a), .B(b), .TC(tc), .in_valid(in_valid),
        .in_ready(rdy[2]), .flush(flush), .PRODUCT(prod[2]), .out_valid(ov[2]),
        .out_ready(out_ready));

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input logic t);
        int r;
        if (t) r = int'($signed(x)) * int'($signed(y));
        else   r = int'(x) * int'(y);
        return r[15:0];
    endfunction

    // Inputs only change just after a rising edge, so the mid-cycle view
    // tells exactly what the next edge will accept and transfer.
    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || flush) begin
                sbq[k].delete();
            end else begin
                if (ov[k] && out_ready) begin
                    total++;
                    if (sbq[k].size() == 0) begin
                        bad++;
                        $display("FAIL sb%0d unexpected output product=%h", k, prod[k]);
                    end else begin
                        sb_exp = sbq[k].pop_front();
                        if (prod[k] !== sb_exp) begin
                            bad++;
                            $display("FAIL sb%0d product got=%h want=%h", k, prod[k], sb_exp);
                        end
                    end
                end
                if (in_valid && rdy[k]) sbq[k].push_back(ref_mul(a, b, tc));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic t,
                         input logic v);
        a = x; b = y; tc = t; in_valid = v;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        repeat (2) step();
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_valid%0d got=%b want=0", k, ov[k]); end
            total++;
            if (prod[k] !== 16'h0) begin bad++; $display("FAIL reset_product%0d got=%h want=0000", k, prod[k]); end
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int k0;
        int cnt [3];
        int seen [3];
        logic [15:0] pr;
        cnt = '{0, 0, 0}; seen = '{-1, -1, -1}; pr = '0;
        drive(8'h80, 8'h7F, 1'b1, 1'b1);
        k0 = cyc + 1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    cnt[k]++; seen[k] = cyc;
                    if (k == 0) pr = prod[0];
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cnt[k] !== 1 || seen[k] !== k0 + lat[k] - 1) begin
                bad++;
                $display("FAIL single_latency%0d count=%0d cycle=%0d want count=1 cycle=%0d",
                         k, cnt[k], seen[k], k0 + lat[k] - 1);
            end
        end
        total++;
        if (pr !== 16'hC080) begin bad++; $display("FAIL single_product got=%h want=c080", pr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta [3] = '{8'hFF, 8'hFF, 8'h80};
        logic [7:0]  ba [3] = '{8'hFF, 8'hFF, 8'h80};
        logic        tt [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] te [3] = '{16'hFE01, 16'h0001, 16'h4000};
        int k0;
        idle(12);
        k0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], ba[i], tt[i], 1'b1);
            @(negedge CLK);
            total++;
            if (rdy[0] !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, rdy[0]); end
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (ov[0] !== 1'b1 || prod[0] !== te[i] || cyc !== k0 + 2 + i) begin
                bad++;
                $display("FAIL b2b_out%0d valid=%b product=%h cycle=%0d want valid=1 product=%h cycle=%0d",
                         i, ov[0], prod[0], cyc, te[i], k0 + 2 + i);
            end
        end
        @(negedge CLK);
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL b2b_tail valid got=%b want=0", ov[0]); end
    endtask

    task automatic test_stall();
        logic [7:0] sa [3] = '{8'h12, 8'hF0, 8'h7F};
        logic [7:0] sb [3] = '{8'h34, 8'h10, 8'h7F};
        logic       st [3] = '{1'b0, 1'b1, 1'b1};
        idle(12);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(sa[i], sb[i], st[i], 1'b1);
            @(negedge CLK);
            total++;
            if (rdy[0] !== 1'b1) begin bad++; $display("FAIL stall_fill_ready%0d got=%b want=1", i, rdy[0]); end
            step();
        end
        drive(8'h55, 8'h66, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            total++;
            if (rdy[0] !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%b want=0", i, rdy[0]); end
            total++;
            if (ov[0] !== 1'b1 || prod[0] !== ref_mul(sa[0], sb[0], st[0])) begin
                bad++;
                $display("FAIL stall_hold%0d valid=%b product=%h want valid=1 product=%h",
                         i, ov[0], prod[0], ref_mul(sa[0], sb[0], st[0]));
            end
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (ov[0] !== 1'b1 || prod[0] !== ref_mul(sa[i], sb[i], st[i])) begin
                bad++;
                $display("FAIL stall_drain%0d valid=%b product=%h want valid=1 product=%h",
                         i, ov[0], prod[0], ref_mul(sa[i], sb[i], st[i]));
            end
        end
        @(negedge CLK);
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL stall_empty valid got=%b want=0", ov[0]); end
    endtask

    task automatic test_flush();
        int k0;
        int cnt;
        int seen;
        logic [15:0] pr;
        cnt = 0; seen = -1; pr = '0;
        idle(12);
        drive(8'h11, 8'h22, 1'b0, 1'b1); step();
        drive(8'hE5, 8'h07, 1'b1, 1'b1); step();
        drive(8'h9C, 8'h3B, 1'b1, 1'b1);
        flush = 1'b1;
        @(negedge CLK);
        total++;
        if (rdy[0] !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", rdy[0]); end
        step();
        flush = 1'b0;
        @(negedge CLK);
        total++;
        if (ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL flush_after valid=%b ready=%b want valid=0 ready=1", ov[0], rdy[0]);
        end
        k0 = cyc + 1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (ov[0]) begin cnt++; seen = cyc; pr = prod[0]; end
        end
        total++;
        if (cnt !== 1 || seen !== k0 + 2 || pr !== ref_mul(8'h9C, 8'h3B, 1'b1)) begin
            bad++;
            $display("FAIL flush_resume count=%0d cycle=%0d product=%h want count=1 cycle=%0d product=%h",
                     cnt, seen, pr, k0 + 2, ref_mul(8'h9C, 8'h3B, 1'b1));
        end
    endtask

    task automatic test_async_reset();
        int k0;
        int cnt;
        int seen;
        logic [15:0] pr;
        cnt = 0; seen = -1; pr = '0;
        idle(12);
        drive(8'h21, 8'h43, 1'b0, 1'b1); step();
        drive(8'hA5, 8'h5A, 1'b1, 1'b1); step();
        drive(8'h7E, 8'h81, 1'b1, 1'b1); step();
        in_valid = 1'b0;
        total++;
        if (ov[0] !== 1'b1) begin bad++; $display("FAIL areset_pre valid got=%b want=1", ov[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ov[k] !== 1'b0 || prod[k] !== 16'h0) begin
                bad++;
                $display("FAIL areset_clear%0d valid=%b product=%h want valid=0 product=0000",
                         k, ov[k], prod[k]);
            end
        end
        step();
        rst_n = 1'b1;
        drive(8'hC3, 8'h5A, 1'b1, 1'b1);
        k0 = cyc + 1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (ov[0]) begin cnt++; seen = cyc; pr = prod[0]; end
        end
        total++;
        if (cnt !== 1 || seen !== k0 + 2 || pr !== ref_mul(8'hC3, 8'h5A, 1'b1)) begin
            bad++;
            $display("FAIL areset_resume count=%0d cycle=%0d product=%h want count=1 cycle=%0d product=%h",
                     cnt, seen, pr, k0 + 2, ref_mul(8'hC3, 8'h5A, 1'b1));
        end
    endtask

    task automatic test_random();
        idle(12);
        for (int i = 0; i < 600; i++) begin
            a         = 8'($urandom);
            b         = 8'($urandom);
            tc        = 1'($urandom);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        idle(20);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (sbq[k].size() != 0) begin
                bad++;
                $display("FAIL random_drain%0d pending=%0d want=0", k, sbq[k].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
